// File: rtl/spio_spinnaker_link_pkg.sv
// Shared definitions for the SpiNNaker-link receive checker.
// Holds the 72-bit packet field ranges, the NRZ 2-of-7 symbol codes, the
// short/long flit counts, the receiver FSM state type and the symbol decoder.
package spio_spinnaker_link_pkg;

  localparam int PKT_BITS        = 72;
  localparam int PKT_HDR_RNG_LO  = 0;
  localparam int PKT_HDR_RNG_HI  = 7;
  localparam int PKT_KEY_RNG_LO  = 8;
  localparam int PKT_KEY_RNG_HI  = 39;
  localparam int PKT_PLD_RNG_LO  = 40;
  localparam int PKT_PLD_RNG_HI  = 71;

  // Transition patterns (old ^ new) for nibbles 0..F and end-of-packet.
  localparam logic [6:0] SYM_NIB_0 = 7'b0010001;
  localparam logic [6:0] SYM_NIB_1 = 7'b0010010;
  localparam logic [6:0] SYM_NIB_2 = 7'b0010100;
  localparam logic [6:0] SYM_NIB_3 = 7'b0011000;
  localparam logic [6:0] SYM_NIB_4 = 7'b0100001;
  localparam logic [6:0] SYM_NIB_5 = 7'b0100010;
  localparam logic [6:0] SYM_NIB_6 = 7'b0100100;
  localparam logic [6:0] SYM_NIB_7 = 7'b0101000;
  localparam logic [6:0] SYM_NIB_8 = 7'b1000001;
  localparam logic [6:0] SYM_NIB_9 = 7'b1000010;
  localparam logic [6:0] SYM_NIB_A = 7'b1000100;
  localparam logic [6:0] SYM_NIB_B = 7'b1001000;
  localparam logic [6:0] SYM_NIB_C = 7'b0000011;
  localparam logic [6:0] SYM_NIB_D = 7'b0000110;
  localparam logic [6:0] SYM_NIB_E = 7'b0001100;
  localparam logic [6:0] SYM_NIB_F = 7'b0001001;
  localparam logic [6:0] SYM_EOP   = 7'b1100000;

  localparam logic [4:0] FLITS_SHORT = 5'd10;
  localparam logic [4:0] FLITS_LONG  = 5'd18;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_WAIT = 2'd1,
    ST_DLY  = 2'd2
  } rx_state_t;

  typedef struct packed {
    logic       legal;
    logic       eop;
    logic       illegal;
    logic [3:0] nibble;
  } sym_dec_t;

  // Classify a transition pattern. Patterns that are neither a code nor
  // EOP are illegal once two or more bits have changed; with 0 or 1 bits
  // changed the symbol is still arriving and all flags stay low.
  function automatic sym_dec_t decode_sym(input logic [6:0] x);
    sym_dec_t d;
    d = '0;
    case (x)
      SYM_NIB_0: begin d.legal = 1'b1; d.nibble = 4'h0; end
      SYM_NIB_1: begin d.legal = 1'b1; d.nibble = 4'h1; end
      SYM_NIB_2: begin d.legal = 1'b1; d.nibble = 4'h2; end
      SYM_NIB_3: begin d.legal = 1'b1; d.nibble = 4'h3; end
      SYM_NIB_4: begin d.legal = 1'b1; d.nibble = 4'h4; end
      SYM_NIB_5: begin d.legal = 1'b1; d.nibble = 4'h5; end
      SYM_NIB_6: begin d.legal = 1'b1; d.nibble = 4'h6; end
      SYM_NIB_7: begin d.legal = 1'b1; d.nibble = 4'h7; end
      SYM_NIB_8: begin d.legal = 1'b1; d.nibble = 4'h8; end
      SYM_NIB_9: begin d.legal = 1'b1; d.nibble = 4'h9; end
      SYM_NIB_A: begin d.legal = 1'b1; d.nibble = 4'hA; end
      SYM_NIB_B: begin d.legal = 1'b1; d.nibble = 4'hB; end
      SYM_NIB_C: begin d.legal = 1'b1; d.nibble = 4'hC; end
      SYM_NIB_D: begin d.legal = 1'b1; d.nibble = 4'hD; end
      SYM_NIB_E: begin d.legal = 1'b1; d.nibble = 4'hE; end
      SYM_NIB_F: begin d.legal = 1'b1; d.nibble = 4'hF; end
      SYM_EOP:   d.eop = 1'b1;
      // x & (x - 1) is non-zero exactly when two or more bits are set
      default:   d.illegal = ((x & (x - 7'd1)) != 7'd0);
    endcase
    return d;
  endfunction

endpackage

// File: rtl/spio_spinnaker_link_rx_checker_fifo.sv
// Expected-packet queue for the link receive checker.
// Ports: tb_clk/tb_rst (async active-high), push_data/push_vld (write side,
// accepted when rdy), rdy (registered, high when not full), pop (remove head,
// ignored when empty), head (oldest entry), empty.
module spio_spinnaker_link_rx_checker_fifo
  import spio_spinnaker_link_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                tb_clk,
  input  logic                tb_rst,
  input  logic [PKT_BITS-1:0] push_data,
  input  logic                push_vld,
  output logic                rdy,
  input  logic                pop,
  output logic [PKT_BITS-1:0] head,
  output logic                empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [PKT_BITS-1:0] mem_r [DEPTH];
  logic [AW-1:0]       wr_ptr_r;
  logic [AW-1:0]       rd_ptr_r;
  logic [AW:0]         count_r;
  logic [AW:0]         count_s;
  logic                rdy_r;
  logic                push_s;
  logic                pop_s;

  // rdy_r is exactly !full, so a push is refused while full even if a pop
  // happens in the same cycle.
  assign push_s = push_vld & rdy_r;
  assign pop_s  = pop & (count_r != '0);

  // Next occupancy from the accepted push/pop pair.
  always_comb begin
    count_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_s = count_r + (AW + 1)'(1);
      2'b01:   count_s = count_r - (AW + 1)'(1);
      default: count_s = count_r;
    endcase
  end

  // Pointers, occupancy and registered ready; pointers wrap naturally.
  always_ff @(posedge tb_clk or posedge tb_rst) begin
    if (tb_rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      rdy_r    <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      count_r <= count_s;
      rdy_r   <= (count_s != FULL_CNT);
    end
  end

  // Storage array; contents are only meaningful behind valid pointers.
  always_ff @(posedge tb_clk) begin
    if (push_s) mem_r[wr_ptr_r] <= push_data;
  end

  assign rdy   = rdy_r;
  assign head  = mem_r[rd_ptr_r];
  assign empty = (count_r == '0);

endmodule

// File: rtl/spio_spinnaker_link_rx_checker.sv
// Clocked SpiNNaker-link receiver and packet checker for link benches.
// Samples an NRZ 2-of-7 link, assembles flits into 72-bit packets, acks
// each symbol after ACK_DLY_IN+1 cycles and checks packets against a queue.
// Ports: tb_clk/tb_rst; EXP_DATA_IN/EXP_VLD_IN/EXP_RDY_OUT expected-packet
// push; SL_DATA_2OF7_IN/SL_ACK_OUT link; ACK_DLY_IN ack delay; PKT_CNT_OUT,
// ERR_CNT_OUT saturating counters; BAD_PKT_OUT, FLT_ERR_OUT, UNDERFLOW_OUT
// one-cycle error pulses.
module spio_spinnaker_link_rx_checker
  import spio_spinnaker_link_pkg::*;
#(
  parameter int EXP_DEPTH   = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DLY_BITS    = 8,
  parameter int CNT_BITS    = 32
) (
  input  logic                tb_clk,
  input  logic                tb_rst,
  input  logic [71:0]         EXP_DATA_IN,
  input  logic                EXP_VLD_IN,
  output logic                EXP_RDY_OUT,
  input  logic [6:0]          SL_DATA_2OF7_IN,
  output logic                SL_ACK_OUT,
  input  logic [DLY_BITS-1:0] ACK_DLY_IN,
  output logic [CNT_BITS-1:0] PKT_CNT_OUT,
  output logic [CNT_BITS-1:0] ERR_CNT_OUT,
  output logic                BAD_PKT_OUT,
  output logic                FLT_ERR_OUT,
  output logic                UNDERFLOW_OUT
);

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (&v) ? v : v + CNT_BITS'(1);
  endfunction

  logic [6:0]          sync_r [SYNC_STAGES];
  logic [6:0]          sd_s;
  sym_dec_t            dec_s;
  rx_state_t           state_r, state_s;
  logic                ack_r, ack_s;
  logic [6:0]          old_r, old_s;
  logic [DLY_BITS-1:0] dly_r, dly_s;
  logic [71:0]         pkt_r, pkt_s;
  logic [4:0]          flit_cnt_r, flit_cnt_s;
  logic                skip_r, skip_s;
  logic [CNT_BITS-1:0] pkt_cnt_r, pkt_cnt_s;
  logic [CNT_BITS-1:0] err_cnt_r, err_cnt_s;
  logic                bad_pkt_r, bad_pkt_s;
  logic                flt_err_r, flt_err_s;
  logic                underflow_r, underflow_s;
  logic                pop_s;
  logic [71:0]         head_s;
  logic                empty_s;
  logic [6:0]          nib_lsb_s;
  logic [4:0]          exp_len_s;
  logic                len_ok_s;
  logic                frame_err_s;
  logic                mism_s;

  spio_spinnaker_link_rx_checker_fifo #(.DEPTH(EXP_DEPTH)) u_fifo (
    .tb_clk    (tb_clk),
    .tb_rst    (tb_rst),
    .push_data (EXP_DATA_IN),
    .push_vld  (EXP_VLD_IN),
    .rdy       (EXP_RDY_OUT),
    .pop       (pop_s),
    .head      (head_s),
    .empty     (empty_s)
  );

  // Link synchroniser. Left out of reset on purpose: it keeps tracking the
  // link during reset so INIT captures the true line state as `old`.
  always_ff @(posedge tb_clk) begin
    sync_r[0] <= SL_DATA_2OF7_IN;
    for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
  end

  assign sd_s      = sync_r[SYNC_STAGES-1];
  assign dec_s     = decode_sym(sd_s ^ old_r);
  assign nib_lsb_s = {flit_cnt_r, 2'b00};

  // End-of-packet checks. A packet already dropped by an illegal symbol or
  // flit overflow has reported its fault, so its fields are not re-judged.
  assign exp_len_s   = head_s[PKT_HDR_RNG_LO+1] ? FLITS_LONG : FLITS_SHORT;
  assign len_ok_s    = (flit_cnt_r == FLITS_SHORT) || (flit_cnt_r == FLITS_LONG);
  assign frame_err_s = !skip_r && (!len_ok_s || (!empty_s && (flit_cnt_r != exp_len_s)));
  assign mism_s      = !empty_s && !skip_r && !frame_err_s &&
                       ((pkt_r[PKT_HDR_RNG_HI:PKT_HDR_RNG_LO] != head_s[PKT_HDR_RNG_HI:PKT_HDR_RNG_LO]) ||
                        (pkt_r[PKT_KEY_RNG_HI:PKT_KEY_RNG_LO] != head_s[PKT_KEY_RNG_HI:PKT_KEY_RNG_LO]) ||
                        (head_s[PKT_HDR_RNG_LO+1] &&
                         (pkt_r[PKT_PLD_RNG_HI:PKT_PLD_RNG_LO] != head_s[PKT_PLD_RNG_HI:PKT_PLD_RNG_LO])));

  // Receiver FSM next state, assembly, counters and pulse generation.
  always_comb begin
    state_s     = state_r;
    ack_s       = ack_r;
    old_s       = old_r;
    dly_s       = dly_r;
    pkt_s       = pkt_r;
    flit_cnt_s  = flit_cnt_r;
    skip_s      = skip_r;
    pkt_cnt_s   = pkt_cnt_r;
    err_cnt_s   = err_cnt_r;
    bad_pkt_s   = 1'b0;
    flt_err_s   = 1'b0;
    underflow_s = 1'b0;
    pop_s       = 1'b0;
    case (state_r)
      ST_INIT: begin
        ack_s   = 1'b1;
        old_s   = sd_s;
        state_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (dec_s.legal || dec_s.eop || dec_s.illegal) begin
          dly_s   = ACK_DLY_IN;
          state_s = ST_DLY;
          if (dec_s.illegal) begin
            flt_err_s = 1'b1;
            skip_s    = 1'b1;
          end else if (dec_s.eop) begin
            pkt_cnt_s   = sat_inc(pkt_cnt_r);
            flt_err_s   = frame_err_s;
            bad_pkt_s   = mism_s;
            underflow_s = empty_s;
            pop_s       = !empty_s;
            if (skip_r || frame_err_s || mism_s || empty_s) begin
              err_cnt_s = sat_inc(err_cnt_r);
            end else begin
              err_cnt_s = err_cnt_r;
            end
            flit_cnt_s = 5'd0;
            skip_s     = 1'b0;
            pkt_s      = 72'd0;
          end else if (skip_r) begin
            flit_cnt_s = flit_cnt_r;
          end else if (flit_cnt_r < FLITS_LONG) begin
            pkt_s[nib_lsb_s +: 4] = dec_s.nibble;
            flit_cnt_s            = flit_cnt_r + 5'd1;
          end else begin
            // 19th data flit: too long for any packet
            flit_cnt_s = flit_cnt_r + 5'd1;
            flt_err_s  = 1'b1;
            skip_s     = 1'b1;
          end
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_DLY: begin
        if (dly_r == '0) begin
          ack_s   = ~ack_r;
          old_s   = sd_s;
          state_s = ST_WAIT;
        end else begin
          dly_s = dly_r - DLY_BITS'(1);
        end
      end
      default: state_s = ST_INIT;
    endcase
  end

  // Receiver state and registered outputs.
  always_ff @(posedge tb_clk or posedge tb_rst) begin
    if (tb_rst) begin
      state_r     <= ST_INIT;
      ack_r       <= 1'b0;
      old_r       <= 7'd0;
      dly_r       <= '0;
      pkt_r       <= 72'd0;
      flit_cnt_r  <= 5'd0;
      skip_r      <= 1'b0;
      pkt_cnt_r   <= '0;
      err_cnt_r   <= '0;
      bad_pkt_r   <= 1'b0;
      flt_err_r   <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      ack_r       <= ack_s;
      old_r       <= old_s;
      dly_r       <= dly_s;
      pkt_r       <= pkt_s;
      flit_cnt_r  <= flit_cnt_s;
      skip_r      <= skip_s;
      pkt_cnt_r   <= pkt_cnt_s;
      err_cnt_r   <= err_cnt_s;
      bad_pkt_r   <= bad_pkt_s;
      flt_err_r   <= flt_err_s;
      underflow_r <= underflow_s;
    end
  end

  assign SL_ACK_OUT    = ack_r;
  assign PKT_CNT_OUT   = pkt_cnt_r;
  assign ERR_CNT_OUT   = err_cnt_r;
  assign BAD_PKT_OUT   = bad_pkt_r;
  assign FLT_ERR_OUT   = flt_err_r;
  assign UNDERFLOW_OUT = underflow_r;

endmodule
